// File: rtl/fp_regfile_wb_pkg.sv
// FPU opcode constants and the opcode-class helpers shared with the FPU decoder.
package fp_regfile_wb_pkg;

  localparam logic [3:0] FOP_ADD = 4'd2;
  localparam logic [3:0] FOP_SUB = 4'd3;
  localparam logic [3:0] FOP_CEQ = 4'd4;
  localparam logic [3:0] FOP_CNE = 4'd5;
  localparam logic [3:0] FOP_CLT = 4'd6;
  localparam logic [3:0] FOP_CLE = 4'd7;
  localparam logic [3:0] FOP_CGT = 4'd8;
  localparam logic [3:0] FOP_MOV = 4'd9;

  // Arithmetic and move results land in the register file.
  function automatic logic fop_writes_reg(input logic [3:0] op);
    return (op == FOP_ADD) || (op == FOP_SUB) || (op == FOP_MOV);
  endfunction

  // Compare results only update the condition flag.
  function automatic logic fop_is_cmp(input logic [3:0] op);
    return (op >= FOP_CEQ) && (op <= FOP_CGT);
  endfunction

endpackage

// File: rtl/fp_wb_stage.sv
// One-entry write-back register holding an FPU result for one cycle before
// it retires into the array, plus the address compares used for forwarding.
module fp_wb_stage #(
  parameter int AW     = 5,
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [AW-1:0]    cap_dst,
  input  logic [WIDTH-1:0] cap_data,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_dst,
  output logic [WIDTH-1:0] wb_data,
  output logic             rs_hit,
  output logic             rt_hit
);

  logic             wb_valid_reg;
  logic [AW-1:0]    wb_dst_reg;
  logic [WIDTH-1:0] wb_data_reg;

  // Load a new entry every cycle; the entry is valid only when a writing op was captured.
  // A capture in the same cycle as a retire simply replaces the retiring entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_reg <= 1'b0;
      wb_dst_reg   <= '0;
      wb_data_reg  <= '0;
    end else begin
      wb_valid_reg <= capture;
      if (capture) begin
        wb_dst_reg  <= cap_dst;
        wb_data_reg <= cap_data;
      end
    end
  end

  assign wb_valid = wb_valid_reg;
  assign wb_dst   = wb_dst_reg;
  assign wb_data  = wb_data_reg;

  // Forwarding is compiled out entirely when BYPASS is 0.
  assign rs_hit = (BYPASS != 0) && wb_valid_reg && (wb_dst_reg == rs_addr);
  assign rt_hit = (BYPASS != 0) && wb_valid_reg && (wb_dst_reg == rt_addr);

endmodule

// File: rtl/fp_regfile_wb.sv
// Single-precision FP register file with a one-stage write-back pipeline,
// FP condition flag, and an mtc1 write port sharing the single array write port.
module fp_regfile_wb
  import fp_regfile_wb_pkg::*;
#(
  parameter  int NREGS  = 32,
  parameter  int WIDTH  = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  input  logic             fpu_valid,
  input  logic [3:0]       fpu_op,
  input  logic [AW-1:0]    fpu_dst,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             mtc1_valid,
  output logic             mtc1_ready,
  input  logic [AW-1:0]    mtc1_dst,
  input  logic [WIDTH-1:0] mtc1_data,
  output logic             cc
);

  logic [WIDTH-1:0] rf_reg [NREGS];
  logic             cc_reg;

  logic             wb_valid;
  logic [AW-1:0]    wb_dst;
  logic [WIDTH-1:0] wb_data;
  logic             rs_hit;
  logic             rt_hit;

  logic             capture;
  logic             mtc1_accept;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NREGS-1:0] wr_sel;

  assign capture = fpu_valid && fop_writes_reg(fpu_op);

  fp_wb_stage #(
    .AW     (AW),
    .WIDTH  (WIDTH),
    .BYPASS (BYPASS)
  ) u_wb_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .cap_dst  (fpu_dst),
    .cap_data (fpu_result),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .wb_valid (wb_valid),
    .wb_dst   (wb_dst),
    .wb_data  (wb_data),
    .rs_hit   (rs_hit),
    .rt_hit   (rt_hit)
  );

  // A pending WB entry owns the write port, so mtc1 waits whenever one is present.
  assign mtc1_ready  = rst_n & ~wb_valid;
  assign mtc1_accept = mtc1_valid & mtc1_ready;

  assign wr_en   = wb_valid | mtc1_accept;
  assign wr_addr = wb_valid ? wb_dst  : mtc1_dst;
  assign wr_data = wb_valid ? wb_data : mtc1_data;

  // One-hot write select per register; $f0 is an ordinary writable register.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
    end
  endgenerate

  // Register array: cleared on reset, otherwise written through the shared port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!rst_n) begin
        rf_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        rf_reg[i] <= wr_data;
      end
    end
  end

  // Condition flag takes bit 0 of a compare result; all other ops leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_reg <= 1'b0;
    end else if (fpu_valid && fop_is_cmp(fpu_op)) begin
      cc_reg <= fpu_result[0];
    end
  end

  assign cc = cc_reg;

  // Combinational reads; a same-cycle mtc1 write is not forwarded.
  assign rs_data = rs_hit ? wb_data : rf_reg[rs_addr];
  assign rt_data = rt_hit ? wb_data : rf_reg[rt_addr];

endmodule

// File: tb/tb_fp_regfile_wb.sv
// Directed bench: one instance with forwarding, one without, sharing all inputs.
module tb_fp_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        fpu_valid;
  logic [3:0]  fpu_op;
  logic [4:0]  fpu_dst;
  logic [31:0] fpu_result;
  logic        mtc1_valid;
  logic [4:0]  mtc1_dst;
  logic [31:0] mtc1_data;

  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mtc1_ready;
  logic        cc;
  logic [31:0] nb_rs_data;
  logic [31:0] nb_rt_data;
  logic        nb_mtc1_ready;
  logic        nb_cc;

  int checks = 0;
  int errors = 0;

  fp_regfile_wb #(.NREGS(32), .WIDTH(32), .BYPASS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .fpu_valid  (fpu_valid),
    .fpu_op     (fpu_op),
    .fpu_dst    (fpu_dst),
    .fpu_result (fpu_result),
    .mtc1_valid (mtc1_valid),
    .mtc1_ready (mtc1_ready),
    .mtc1_dst   (mtc1_dst),
    .mtc1_data  (mtc1_data),
    .cc         (cc)
  );

  fp_regfile_wb #(.NREGS(32), .WIDTH(32), .BYPASS(0)) dut_nb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (nb_rs_data),
    .rt_data    (nb_rt_data),
    .fpu_valid  (fpu_valid),
    .fpu_op     (fpu_op),
    .fpu_dst    (fpu_dst),
    .fpu_result (fpu_result),
    .mtc1_valid (mtc1_valid),
    .mtc1_ready (nb_mtc1_ready),
    .mtc1_dst   (mtc1_dst),
    .mtc1_data  (mtc1_data),
    .cc         (nb_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fpu(input logic [3:0] op, input logic [4:0] dst, input logic [31:0] res);
    fpu_valid  = 1'b1;
    fpu_op     = op;
    fpu_dst    = dst;
    fpu_result = res;
  endtask

  task automatic fpu_idle();
    fpu_valid  = 1'b0;
    fpu_op     = 4'd0;
    fpu_result = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
    fpu_valid = 1'b0; fpu_op = 4'd0; fpu_dst = 5'd0; fpu_result = 32'h0;
    mtc1_valid = 1'b0; mtc1_dst = 5'd0; mtc1_data = 32'h0;
    repeat (2) step();

    // 1. Reset behaviour
    check("ready_in_reset", {31'b0, mtc1_ready}, 32'h0);
    rst_n = 1'b1; #1;
    check("ready_after_reset", {31'b0, mtc1_ready}, 32'h1);
    mtc1_valid = 1'b1; mtc1_dst = 5'd3; mtc1_data = 32'h12345678;
    fpu(4'd6, 5'd3, 32'h1);
    step();
    mtc1_valid = 1'b0; fpu_idle();
    rs_addr = 5'd3; #1;
    check("f3_mtc1_written", rs_data, 32'h12345678);
    check("cc_set_before_reset", {31'b0, cc}, 32'h1);
    rst_n = 1'b0; #1;
    check("ready_low_during_reset", {31'b0, mtc1_ready}, 32'h0);
    step();
    rst_n = 1'b1; #1;
    check("f3_cleared_by_reset", rs_data, 32'h0);
    check("cc_cleared_by_reset", {31'b0, cc}, 32'h0);

    // 2. Add latency: bypass after edge N, array after edge N+1
    fpu(4'd2, 5'd5, 32'h40400000);
    rs_addr = 5'd5;
    step();
    fpu_idle(); #1;
    check("add_bypass_edge_n", rs_data, 32'h40400000);
    check("add_nobypass_edge_n", nb_rs_data, 32'h0);
    check("ready_low_wb_pending", {31'b0, mtc1_ready}, 32'h0);
    step();
    check("add_nobypass_edge_n1", nb_rs_data, 32'h40400000);
    check("ready_high_after_retire", {31'b0, mtc1_ready}, 32'h1);

    // 3. Compares touch only cc; unknown ops are ignored
    fpu(4'd6, 5'd5, 32'h1);
    step();
    fpu_idle(); #1;
    check("cmp_sets_cc", {31'b0, cc}, 32'h1);
    check("cmp_no_wb_bypass", rs_data, 32'h40400000);
    check("cmp_no_wb_ready", {31'b0, mtc1_ready}, 32'h1);
    step();
    check("cmp_no_reg_write", nb_rs_data, 32'h40400000);
    fpu(4'd4, 5'd5, 32'h0);
    step();
    fpu_idle(); #1;
    check("cmp_clears_cc", {31'b0, cc}, 32'h0);
    fpu(4'd0, 5'd5, 32'h1);
    step();
    fpu_idle(); #1;
    check("ignored_op_cc", {31'b0, cc}, 32'h0);
    check("ignored_op_ready", {31'b0, mtc1_ready}, 32'h1);
    step();
    check("ignored_op_reg", nb_rs_data, 32'h40400000);

    // 4. mtc1 stalls exactly one cycle behind a mov capture
    fpu(4'd9, 5'd8, 32'h11111111);
    step();
    fpu_idle();
    mtc1_valid = 1'b1; mtc1_dst = 5'd7; mtc1_data = 32'h3F800000;
    rs_addr = 5'd7; rt_addr = 5'd8; #1;
    check("mtc1_stall_ready", {31'b0, mtc1_ready}, 32'h0);
    step();
    check("mtc1_not_written_in_stall", nb_rs_data, 32'h0);
    check("mtc1_ready_after_stall", {31'b0, mtc1_ready}, 32'h1);
    check("mov_retired", nb_rt_data, 32'h11111111);
    step();
    mtc1_valid = 1'b0; #1;
    check("mtc1_f7_written", rs_data, 32'h3F800000);

    // $f0 is writable
    mtc1_valid = 1'b1; mtc1_dst = 5'd0; mtc1_data = 32'hCAFEF00D;
    step();
    mtc1_valid = 1'b0; rs_addr = 5'd0; #1;
    check("f0_writable", rs_data, 32'hCAFEF00D);

    // 5. Back-to-back results to the same destination
    rt_addr = 5'd9;
    fpu(4'd2, 5'd9, 32'h3F000000);
    step();
    fpu(4'd3, 5'd9, 32'h40000000); #1;
    check("b2b_first_bypass", rt_data, 32'h3F000000);
    check("b2b_first_nobypass", nb_rt_data, 32'h0);
    step();
    fpu_idle(); #1;
    check("b2b_second_bypass", rt_data, 32'h40000000);
    check("b2b_first_retired", nb_rt_data, 32'h3F000000);
    step();
    check("b2b_final_value", nb_rt_data, 32'h40000000);
    check("b2b_final_value_bp", rt_data, 32'h40000000);

    // 6. Reset while a WB entry is pending discards it
    fpu(4'd2, 5'd4, 32'hDEADBEEF);
    rs_addr = 5'd4;
    step();
    fpu_idle();
    rst_n = 1'b0; #1;
    check("pending_before_reset", rs_data, 32'hDEADBEEF);
    step();
    rst_n = 1'b1; #1;
    check("pending_lost_bp", rs_data, 32'h0);
    check("pending_lost_nb", nb_rs_data, 32'h0);
    check("ready_after_pending_reset", {31'b0, mtc1_ready}, 32'h1);
    step();
    check("f4_stays_zero", nb_rs_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
